// File: rtl/bus_arb_pkg.sv
// Shared types and sizing helpers for the memory bus arbiter.
package bus_arb_pkg;

    localparam int unsigned SEL_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        IF_ACC,
        MEM_ACC,
        IF_DONE,
        MEM_DONE
    } state_t;

    // Counter width able to hold values 0..timeout.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// Wait-cycle counter for one bus access; flags the cycle whose count would reach TIMEOUT.
module bus_timeout_cnt
    import bus_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // This un-acked cycle is the TIMEOUT-th wait cycle.
    assign expired = enable && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_arbiter.sv
// Single-port memory bus sequencer: MEM-priority arbitration between fetch and load/store,
// bus handshake with timeout, and per-stage stall requests.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_hold,
    input  logic              flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stallreq,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [SEL_W-1:0]  mem_sel,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_hold,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stallreq,
    output logic              bus_req,
    output logic              bus_we,
    output logic [SEL_W-1:0]  bus_sel,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              bus_err
);

    state_t            state, state_next;
    logic              discard, discard_next;
    logic              bus_req_next, bus_we_next, bus_err_next;
    logic [SEL_W-1:0]  bus_sel_next;
    logic [ADDR_W-1:0] bus_addr_next;
    logic [DATA_W-1:0] bus_wdata_next, if_rdata_next, mem_rdata_next;
    logic              in_acc, tmo_expired;

    assign in_acc = (state == IF_ACC) || (state == MEM_ACC);

    bus_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == IDLE),
        .enable  (in_acc && !bus_ack),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            discard   <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_err   <= 1'b0;
            bus_sel   <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            state     <= state_next;
            discard   <= discard_next;
            bus_req   <= bus_req_next;
            bus_we    <= bus_we_next;
            bus_err   <= bus_err_next;
            bus_sel   <= bus_sel_next;
            bus_addr  <= bus_addr_next;
            bus_wdata <= bus_wdata_next;
            if_rdata  <= if_rdata_next;
            mem_rdata <= mem_rdata_next;
        end
    end

    always_comb begin
        state_next     = state;
        discard_next   = discard;
        bus_req_next   = bus_req;
        bus_we_next    = bus_we;
        bus_err_next   = 1'b0;
        bus_sel_next   = bus_sel;
        bus_addr_next  = bus_addr;
        bus_wdata_next = bus_wdata;
        if_rdata_next  = if_rdata;
        mem_rdata_next = mem_rdata;

        case (state)
            IDLE: begin
                if (mem_req) begin
                    state_next     = MEM_ACC;
                    bus_req_next   = 1'b1;
                    bus_we_next    = mem_we;
                    bus_sel_next   = mem_sel;
                    bus_addr_next  = mem_addr;
                    bus_wdata_next = mem_wdata;
                end else if (if_req && !flush) begin
                    state_next     = IF_ACC;
                    discard_next   = 1'b0;
                    bus_req_next   = 1'b1;
                    bus_we_next    = 1'b0;
                    bus_sel_next   = '1;
                    bus_addr_next  = if_addr;
                    bus_wdata_next = '0;
                end
            end

            IF_ACC: begin
                discard_next = discard || flush;
                if (bus_ack || tmo_expired) begin
                    bus_req_next = 1'b0;
                    bus_we_next  = 1'b0;
                    bus_err_next = !bus_ack;
                    discard_next = 1'b0;
                    // A flushed fetch is dropped even if its data arrives this cycle.
                    if (discard || flush) begin
                        state_next = IDLE;
                    end else begin
                        state_next    = IF_DONE;
                        if_rdata_next = bus_ack ? bus_rdata : '0;
                    end
                end
            end

            MEM_ACC: begin
                if (bus_ack || tmo_expired) begin
                    state_next     = MEM_DONE;
                    bus_req_next   = 1'b0;
                    bus_we_next    = 1'b0;
                    bus_err_next   = !bus_ack;
                    mem_rdata_next = bus_ack ? bus_rdata : '0;
                end
            end

            IF_DONE: begin
                if (flush || !if_hold) begin
                    state_next = IDLE;
                end
            end

            MEM_DONE: begin
                if (!mem_hold) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Stall until the requester's data has been presented in its DONE state.
    assign if_stallreq  = if_req  && (state != IF_DONE);
    assign mem_stallreq = mem_req && (state != MEM_DONE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: inputs driven and outputs checked on the falling clock edge.
module tb_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req, if_hold, flush;
    logic [31:0] if_addr, if_rdata;
    logic        if_stallreq;
    logic        mem_req, mem_we, mem_hold, mem_stallreq;
    logic [3:0]  mem_sel, bus_sel;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        bus_req, bus_we, bus_ack, bus_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    int vectors;
    int miscompares;

    bus_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_hold      (if_hold),
        .flush        (flush),
        .if_rdata     (if_rdata),
        .if_stallreq  (if_stallreq),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_sel      (mem_sel),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_hold     (mem_hold),
        .mem_rdata    (mem_rdata),
        .mem_stallreq (mem_stallreq),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_sel      (bus_sel),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_ack      (bus_ack),
        .bus_err      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
        vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
        vectors++; if (bus_addr !== 32'h0) begin miscompares++; $display("FAIL reset_bus_addr: got %h want 0", bus_addr); end
        vectors++; if (if_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_if_rdata: got %h want 0", if_rdata); end
        vectors++; if (if_stallreq !== 1'b0) begin miscompares++; $display("FAIL reset_if_stallreq: got %b want 0", if_stallreq); end
        rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        if_req = 1'b1; if_addr = 32'h0000_0100;
        @(negedge clk);
        vectors++; if (bus_req !== 1'b1) begin miscompares++; $display("FAIL fetch_grant: got bus_req %b want 1", bus_req); end
        vectors++; if (bus_addr !== 32'h100) begin miscompares++; $display("FAIL fetch_addr: got %h want 00000100", bus_addr); end
        vectors++; if (bus_we !== 1'b0) begin miscompares++; $display("FAIL fetch_we: got %b want 0", bus_we); end
        vectors++; if (if_stallreq !== 1'b1) begin miscompares++; $display("FAIL fetch_stall_acc: got %b want 1", if_stallreq); end
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus_ack = 1'b0;
        vectors++; if (if_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL fetch_rdata: got %h want deadbeef", if_rdata); end
        vectors++; if (if_stallreq !== 1'b0) begin miscompares++; $display("FAIL fetch_stall_done: got %b want 0", if_stallreq); end
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL fetch_req_drop: got %b want 0", bus_req); end
        @(negedge clk);
        vectors++; if (if_stallreq !== 1'b1) begin miscompares++; $display("FAIL fetch_stall_one_cycle: got %b want 1", if_stallreq); end
        if_req = 1'b0;
        @(negedge clk);
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL fetch_no_regrant: got %b want 0", bus_req); end
    endtask

    task automatic test_mem_priority();
        if_req = 1'b1; if_addr = 32'h0000_0200;
        mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011;
        mem_addr = 32'h0000_0300; mem_wdata = 32'h1234_5678;
        @(negedge clk);
        vectors++; if (bus_addr !== 32'h300) begin miscompares++; $display("FAIL prio_addr: got %h want 00000300", bus_addr); end
        vectors++; if (bus_we !== 1'b1) begin miscompares++; $display("FAIL prio_we: got %b want 1", bus_we); end
        vectors++; if (bus_sel !== 4'b0011) begin miscompares++; $display("FAIL prio_sel: got %b want 0011", bus_sel); end
        vectors++; if (bus_wdata !== 32'h1234_5678) begin miscompares++; $display("FAIL prio_wdata: got %h want 12345678", bus_wdata); end
        vectors++; if (if_stallreq !== 1'b1) begin miscompares++; $display("FAIL prio_if_stall_acc: got %b want 1", if_stallreq); end
        bus_ack = 1'b1; bus_rdata = 32'hAAAA_5555;
        @(negedge clk);
        bus_ack = 1'b0;
        vectors++; if (mem_rdata !== 32'hAAAA_5555) begin miscompares++; $display("FAIL prio_mem_rdata: got %h want aaaa5555", mem_rdata); end
        vectors++; if (mem_stallreq !== 1'b0) begin miscompares++; $display("FAIL prio_mem_stall_done: got %b want 0", mem_stallreq); end
        vectors++; if (if_stallreq !== 1'b1) begin miscompares++; $display("FAIL prio_if_stall_done: got %b want 1", if_stallreq); end
        mem_req = 1'b0; mem_we = 1'b0;
        @(negedge clk);
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL prio_idle_gap: got bus_req %b want 0", bus_req); end
        @(negedge clk);
        vectors++; if (bus_addr !== 32'h200) begin miscompares++; $display("FAIL prio_if_addr: got %h want 00000200", bus_addr); end
        vectors++; if (bus_req !== 1'b1 || bus_we !== 1'b0) begin miscompares++; $display("FAIL prio_if_grant: got req %b we %b want 1 0", bus_req, bus_we); end
        bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        bus_ack = 1'b0;
        vectors++; if (if_rdata !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL prio_if_rdata: got %h want 0badf00d", if_rdata); end
        if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_if_hold();
        if_req = 1'b1; if_addr = 32'h0000_0240;
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'h1357_2468;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = 32'hFFFF_0000; if_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++; if (if_rdata !== 32'h1357_2468) begin miscompares++; $display("FAIL hold_rdata[%0d]: got %h want 13572468", i, if_rdata); end
            vectors++; if (if_stallreq !== 1'b0 || bus_req !== 1'b0) begin miscompares++; $display("FAIL hold_state[%0d]: got stall %b req %b want 0 0", i, if_stallreq, bus_req); end
        end
        if_hold = 1'b0;
        @(negedge clk);
        vectors++; if (if_stallreq !== 1'b1) begin miscompares++; $display("FAIL hold_release: got stall %b want 1", if_stallreq); end
        if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_flush();
        if_req = 1'b1; if_addr = 32'h0000_0400;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
        @(negedge clk);
        bus_ack = 1'b0;
        vectors++; if (if_rdata !== 32'h1357_2468) begin miscompares++; $display("FAIL flush_rdata: got %h want 13572468", if_rdata); end
        vectors++; if (if_stallreq !== 1'b1 || bus_req !== 1'b0) begin miscompares++; $display("FAIL flush_to_idle: got stall %b req %b want 1 0", if_stallreq, bus_req); end
        if_req = 1'b0;
        @(negedge clk);
        if_req = 1'b1; flush = 1'b1;
        @(negedge clk);
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL flush_blocks_grant: got %b want 0", bus_req); end
        if_req = 1'b0; flush = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h0000_0500;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++; if (bus_req !== 1'b1 || bus_err !== 1'b0) begin miscompares++; $display("FAIL tmo_wait[%0d]: got req %b err %b want 1 0", i, bus_req, bus_err); end
        end
        @(negedge clk);
        vectors++; if (bus_err !== 1'b1) begin miscompares++; $display("FAIL tmo_err_pulse: got %b want 1", bus_err); end
        vectors++; if (mem_rdata !== 32'h0) begin miscompares++; $display("FAIL tmo_rdata: got %h want 0", mem_rdata); end
        vectors++; if (mem_stallreq !== 1'b0 || bus_req !== 1'b0) begin miscompares++; $display("FAIL tmo_done: got stall %b req %b want 0 0", mem_stallreq, bus_req); end
        mem_req = 1'b0;
        @(negedge clk);
        vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("FAIL tmo_err_one_cycle: got %b want 0", bus_err); end
    endtask

    task automatic test_reset_mid_access();
        if_req = 1'b1; if_addr = 32'h0000_0700;
        mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'hF;
        mem_addr = 32'h0000_0600; mem_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        vectors++; if (bus_req !== 1'b1) begin miscompares++; $display("FAIL rstmid_grant: got %b want 1", bus_req); end
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (bus_req !== 1'b0 || bus_we !== 1'b0 || bus_err !== 1'b0) begin miscompares++; $display("FAIL rstmid_ctrl: got req %b we %b err %b want 0 0 0", bus_req, bus_we, bus_err); end
        vectors++; if (bus_sel !== 4'h0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin miscompares++; $display("FAIL rstmid_bus: got sel %h addr %h wdata %h want 0 0 0", bus_sel, bus_addr, bus_wdata); end
        vectors++; if (if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin miscompares++; $display("FAIL rstmid_rdata: got if %h mem %h want 0 0", if_rdata, mem_rdata); end
        vectors++; if (mem_stallreq !== 1'b1 || if_stallreq !== 1'b1) begin miscompares++; $display("FAIL rstmid_stall: got mem %b if %b want 1 1", mem_stallreq, if_stallreq); end
        rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0; if_req = 1'b0;
        @(negedge clk);
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL rstmid_idle: got %b want 0", bus_req); end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0; if_hold = 1'b0; flush = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_sel = '0; mem_addr = '0; mem_wdata = '0; mem_hold = 1'b0;
        bus_ack = 1'b0; bus_rdata = '0;
        test_reset();
        test_single_fetch();
        test_mem_priority();
        test_if_hold();
        test_flush();
        test_timeout();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Sequencer and arbiter for the single shared memory bus port of the 5-stage pipeline. It serves the instruction-fetch (IF) requester and the load/store (MEM) requester one access at a time, with MEM given priority. It drives the shared bus handshake and bounds each access with a timeout. It also raises per-stage stall requests, which feed the pipeline stall controller until each requester's data is delivered.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles waiting for bus_ack (≥1)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request; addr held stable while if_stallreq=1
- if_addr  in  ADDR_W  fetch address
- if_hold  in  1  IF/ID stage frozen this cycle (from stall vector)
- flush  in  1  discard any pending/undelivered fetch
- if_rdata  out  DATA_W  fetched word, valid when state=IF_DONE
- if_stallreq  out  1  fetch not yet delivered
- mem_req, mem_we  in  1  data access request / write
- mem_sel  in  4  byte enables
- mem_addr, mem_wdata  in  ADDR_W/DATA_W  data address / store data
- mem_hold  in  1  MEM/WB stage frozen this cycle
- mem_rdata  out  DATA_W  load word, valid when state=MEM_DONE
- mem_stallreq  out  1  data access not yet delivered
- bus_req, bus_we  out  1  bus cycle active / write
- bus_sel  out  4;  bus_addr, bus_wdata  out  ADDR_W/DATA_W
- bus_rdata  in  DATA_W;  bus_ack  in  1  access complete
- bus_err  out  1  one-cycle pulse on timeout

## Operation
- States: IDLE, IF_ACC, MEM_ACC, IF_DONE, MEM_DONE.
- IDLE: mem_req → MEM_ACC, else if_req && !flush → IF_ACC. Bus address, data, sel and we are registered on this transition.
- X_ACC: bus_req=1. On bus_ack, bus_rdata is latched into X_rdata → X_DONE. bus_ack is ignored outside ACC states.
- No preemption: a request arriving mid-access waits for IDLE.
- X_DONE: stays while X_hold=1. When X_hold=0 → IDLE.
- if_stallreq = if_req && state≠IF_DONE.
- mem_stallreq = mem_req && state≠MEM_DONE.
- Outputs are derived from registered state, so no combinational path runs from bus inputs or hold inputs to the stallreq outputs.
- Flush handling:
  - flush in IF_ACC sets a discard flag; on ack the FSM goes → IDLE, not IF_DONE.
  - flush in IF_DONE → IDLE.
  - flush in IDLE blocks the IF grant that cycle.
  - flush never affects MEM accesses.
- Timeout: a cycle counter is cleared on entering an ACC state and increments each ACC cycle without ack. When it reaches TIMEOUT, bus_err pulses, X_rdata is set to 0, and the FSM goes → X_DONE (or IDLE if the fetch is discarded).
- Reset values: state IDLE; bus_req, bus_we, bus_err = 0; bus_sel = 0; all data and address outputs = 0; discard flag and counter = 0.
- Reset mid-access drops bus_req at the next edge and returns the FSM to IDLE.

## Timing
- Grant latency: request seen in IDLE at cycle N → bus_req=1 at N+1.
- With ack at cycle N+k (k≥1), DONE is entered at N+k+1; stallreq falls and rdata is valid in that cycle.
- Minimum 3 cycles per access with zero-wait ack. Back-to-back accesses always pass through IDLE.
- Simultaneous if_req and mem_req in IDLE: MEM is granted and IF waits, so the IF access starts ≥1 cycle after MEM_DONE exits.
- Simultaneous ack and timeout: ack wins, bus_err=0.
- Simultaneous flush and ack in IF_ACC: result discarded → IDLE.

## Structure
- Package bus_arb_pkg: state enum (5 states), SEL_W=4, timeout counter width $clog2(TIMEOUT+1) as a function.
- Sub-module bus_timeout_cnt: clear, enable, expired flag.
- Everything else is flat: FSM, request/data registers, stall decode.

## Test plan
- Single fetch, if_addr=0x100, ack 2 cycles after bus_req → bus_addr=0x100, if_rdata=bus_rdata, if_stallreq low exactly 1 cycle with if_hold=0.
- if_req and mem_req both high in IDLE (store, sel=4'b0011) → MEM served first with bus_we=1, then IF. if_stallreq stays high throughout the MEM access.
- IF_DONE with if_hold=1 for 3 cycles → state held, if_rdata stable, no new bus_req.
- flush asserted in IF_ACC, ack next cycle → no IF_DONE, if_rdata unchanged, FSM to IDLE.
- TIMEOUT=4, no ack → bus_err pulses 1 cycle after the 4th wait cycle, mem_rdata=0, FSM to MEM_DONE.
- rst asserted during MEM_ACC → next cycle bus_req=0, both stallreq follow req only, all outputs at reset values.
